// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader feeding the CPU instruction/data memory.
// It receives a framed image (16-bit word count, then big-endian 32-bit words),
// writes the words to consecutive addresses starting at 0, and keeps the CPU
// halted until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte,
// which must match the data bytes or the load fails.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned    MAX_WORDS = 2**ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [2:0] S_HDR_HI = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd3;
`else
  localparam logic [2:0] S_FLUSH  = 3'd4;
`endif
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, done_q, err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic              in_ready_s;
  logic              xfer_s;
  logic [15:0]       hdr_count_s;

  // Ready is a pure decode of the accepting states, masked while in reset.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      S_HDR_HI, S_HDR_LO, S_DATA: in_ready_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:                      in_ready_s = 1'b1;
`endif
      default:                    in_ready_s = 1'b0;
    endcase
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = in_ready_s;
    end
  end

  assign xfer_s      = in_valid && in_ready_s;
  assign hdr_count_s = {hdr_hi_q, in_byte};

  // Next-state, word assembly and write-strobe generation.
  always_comb begin
    state_d     = state_q;
    hdr_hi_d    = hdr_hi_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    case (state_q)
      S_HDR_HI: begin
        if (xfer_s) begin
          hdr_hi_d = in_byte;
          state_d  = S_HDR_LO;
        end else begin
          state_d  = S_HDR_HI;
        end
      end
      S_HDR_LO: begin
        if (xfer_s) begin
          count_d = hdr_count_s[ADDR_W:0];
          if (hdr_count_s > 16'(MAX_WORDS)) begin
            state_d = S_ERROR;
          end else if (hdr_count_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_FLUSH;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_HDR_LO;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          asm_d      = {asm_q[15:0], in_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ in_byte;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_idx_q[ADDR_W-1:0];
            mem_wdata_d = {asm_q, in_byte};
            word_idx_d  = word_idx_q + IDX_ONE;
            if ((word_idx_q + IDX_ONE) == count_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_FLUSH;
`endif
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer_s) begin
          state_d = (in_byte == xor_q) ? S_DONE : S_ERROR;
        end else begin
          state_d = S_CHK;
        end
      end
`else
      S_FLUSH: begin
        state_d = S_DONE;
      end
`endif
      S_DONE, S_ERROR: begin
        // Rearm starts a fresh image; memory itself is left untouched.
        if (rearm) begin
          state_d    = S_HDR_HI;
          word_idx_d = '0;
          byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = 8'h00;
`endif
        end else begin
          state_d    = state_q;
        end
      end
      default: begin
        state_d = S_HDR_HI;
      end
    endcase
  end

  // State and output registers; reset discards any partial word and pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HDR_HI;
      hdr_hi_q    <= 8'h00;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 24'h000000;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h00000000;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      hdr_hi_q    <= hdr_hi_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERROR);
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign in_ready  = in_ready_s;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
